// File: rtl/tt_alu_pkg.sv
// Shared opcode encoding and inmode bit positions for the tt_alu pipeline.
package tt_alu_pkg;

   typedef enum logic [1:0] {
      OP_MUL = 2'b00,
      OP_ADD = 2'b01,
      OP_SUB = 2'b10,
      OP_XOR = 2'b11
   } op_e;

   localparam int INMODE_ACC = 0;
   localparam int INMODE_CAT = 1;

endpackage

// File: rtl/tt_alu_core.sv
// Purely combinational unsigned ALU, modulo 2^R_W: MUL/ADD/SUB(BC-A)/XOR of A against BC.
// No state, no handshake; borrow is meaningful only for SUB.
module tt_alu_core
   import tt_alu_pkg::*;
#(
   parameter int A_W = 4,
   parameter int R_W = 10
) (
   input  logic [A_W-1:0] i_a,
   input  logic [R_W-1:0] i_bc,
   input  op_e            i_op,
   output logic [R_W-1:0] o_res,
   output logic           o_borrow
);

   logic [R_W-1:0] w_a;
   assign w_a = R_W'(i_a);

   always_comb begin
      o_res    = '0;
      o_borrow = 1'b0;
      case (i_op)
         OP_MUL: o_res = w_a * i_bc;
         OP_ADD: o_res = w_a + i_bc;
         OP_SUB: begin
            o_res    = i_bc - w_a;
            o_borrow = (w_a > i_bc);
         end
         default: o_res = w_a ^ i_bc;
      endcase
   end

endmodule

// File: rtl/tt_alu_pipe.sv
// Two-stage ALU pipe: S1 latches operands, S2 latches result; result valid 2 cycles after accept.
// valid/ready on both sides; S2 holds under out_ready=0, accumulate ops wait until S1 is empty.
module tt_alu_pipe
   import tt_alu_pkg::*;
#(
   parameter int A_W = 4,
   parameter int B_W = 4,
   parameter int C_W = 2
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [A_W-1:0]         a,
   input  logic [B_W-1:0]         b,
   input  logic [C_W-1:0]         c,
   input  logic [1:0]             opcode,
   input  logic [1:0]             inmode,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [A_W+B_W+C_W-1:0] result,
   output logic                   zero,
   output logic                   borrow
);

   localparam int R_W = A_W + B_W + C_W;

   logic           r_rdy_en;
   logic           r_s1_vld;
   logic [A_W-1:0] r_s1_a;
   logic [R_W-1:0] r_s1_bc;
   op_e            r_s1_op;
   logic           r_s2_vld;
   logic [R_W-1:0] r_result;
   logic           r_zero;
   logic           r_borrow;
   logic [R_W-1:0] r_acc;

   logic           w_s2_free;
   logic           w_s1_adv;
   logic           w_hazard;
   logic           w_accept;
   logic [A_W-1:0] w_a_sel;
   logic [R_W-1:0] w_bc;
   logic [R_W-1:0] w_res;
   logic           w_borrow;

   assign w_s2_free = !r_s2_vld || out_ready;
   assign w_s1_adv  = r_s1_vld && w_s2_free;
   // acc is only current once the previous op has left S1
   assign w_hazard  = in_valid && inmode[INMODE_ACC] && r_s1_vld;
   assign in_ready  = r_rdy_en && (!r_s1_vld || w_s1_adv) && !w_hazard;
   assign w_accept  = in_valid && in_ready;

   assign w_a_sel = inmode[INMODE_ACC] ? r_acc[A_W-1:0] : a;
   assign w_bc    = inmode[INMODE_CAT] ? R_W'({c, b}) : (R_W'(b) + R_W'(c));

   tt_alu_core #(
      .A_W (A_W),
      .R_W (R_W)
   ) u_core (
      .i_a      (r_s1_a),
      .i_bc     (r_s1_bc),
      .i_op     (r_s1_op),
      .o_res    (w_res),
      .o_borrow (w_borrow)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rdy_en <= 1'b0;
         r_s1_vld <= 1'b0;
         r_s1_a   <= '0;
         r_s1_bc  <= '0;
         r_s1_op  <= OP_MUL;
      end else begin
         r_rdy_en <= 1'b1;
         if (w_accept) begin
            r_s1_vld <= 1'b1;
            r_s1_a   <= w_a_sel;
            r_s1_bc  <= w_bc;
            r_s1_op  <= op_e'(opcode);
         end else if (w_s1_adv) begin
            r_s1_vld <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s2_vld <= 1'b0;
         r_result <= '0;
         r_zero   <= 1'b0;
         r_borrow <= 1'b0;
         r_acc    <= '0;
      end else if (w_s1_adv) begin
         r_s2_vld <= 1'b1;
         r_result <= w_res;
         r_zero   <= (w_res == '0);
         r_borrow <= w_borrow;
         r_acc    <= w_res;
      end else if (out_ready) begin
         r_s2_vld <= 1'b0;
      end
   end

   assign out_valid = r_s2_vld;
   assign result    = r_result;
   assign zero      = r_zero;
   assign borrow    = r_borrow;

endmodule
